fetch_priv_ctrl: RTL and testbench
==================================

// Module: fetch_priv_ctrl
// PURPOSE
//  Front-end sequencer for barrier/CSR/TLB instructions (ibar, csrwr/csrxchg, tlbfill/tlbwr/invtlb...).
//  Watches each 2-slot bundle leaving the IF1 FIFO; on a pre-decoded privileged slot it kills younger
//  fetch, holds IF until EX reaches the instruction and its side effect completes, then redirects
//  fetch to the next sequential PC. Sits between the IF1 FIFO/pre-decoder and the IF0 PC mux.
// PARAMETERS
//  IDLE_CYC  2   consecutive cycles icache_idle&dcache_idle must hold before ibar completes
//  WDOG_W    10  watchdog counter width; saturation forces completion
// PORTS
//  clk           in   1   clock
//  rstn          in   1   reset, asynchronous, active-low
//  flush         in   1   backend flush (exception/ertn/branch mispredict); highest priority
//  bundle_fire   in   1   IF1 FIFO bundle accepted downstream this cycle (fifo_readygo&fifo_allowin)
//  bundle_pc     in   32  PC of slot 0 of the firing bundle (word aligned)
//  ibar_flag     in   2   per-slot ibar marks, bit0=slot0, bit1=slot1; valid with bundle_fire
//  csr_flag      in   2   per-slot CSR-write marks
//  tlb_flag      in   2   per-slot TLB-op marks
//  ibar_from_ex  in   1   ibar reached EX
//  csr_from_ex   in   1   CSR op reached EX
//  tlb_from_ex   in   1   TLB op reached EX
//  icache_idle   in   1   icache has no outstanding op
//  dcache_idle   in   1   dcache has no outstanding op
//  csr_done      in   1   CSR write committed
//  tlb_done      in   1   TLB op committed
//  fetch_hold    out  1   stall IF0/IF1 (no new fetch request)
//  flush_front   out  1   one-cycle kill of IF0/IF1/FIFO contents younger than the priv slot
//  squash_slot1  out  1   one-cycle: drop slot1 of the firing bundle (priv found in slot0)
//  set_pc        out  1   one-cycle redirect strobe
//  pc_redirect   out  32  redirect target, valid with set_pc
//  wdog_err      out  1   one-cycle pulse when watchdog forced completion
//  busy          out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, pc_redirect=0, counters 0. Async assert, sync use after deassert.
//  Slot select (IDLE & bundle_fire): first slot with any flag set; slot0 before slot1. Kind of that slot:
//   ibar > csr > tlb if several bits set. Latch target = bundle_pc + 4*(slot+1) (32-bit, wraps mod 2^32).
//  States (3-bit): IDLE 000, WAIT_EX_IBAR 001, WAIT_EX_CSR 010, WAIT_EX_TLB 111,
//   WAIT_CACHE_IDLE 011, WAIT_CSR_OK 100, WAIT_TLB_OK 101, REDIRECT 110.
//  IDLE -> WAIT_EX_{kind} on detect; same edge registers flush_front=1 for exactly 1 cycle;
//   squash_slot1 is combinational in the detect cycle when slot0 selected.
//  WAIT_EX_IBAR -> WAIT_CACHE_IDLE on ibar_from_ex; WAIT_EX_CSR -> WAIT_CSR_OK on csr_from_ex;
//   WAIT_EX_TLB -> WAIT_TLB_OK on tlb_from_ex. *_done/idle seen while in WAIT_EX_* are ignored.
//  WAIT_CACHE_IDLE: idle_cnt++ each cycle both idle, cleared on any non-idle cycle; -> REDIRECT when
//   idle_cnt reaches IDLE_CYC-1 with both idle (i.e. IDLE_CYC consecutive idle cycles incl. current).
//  WAIT_CSR_OK -> REDIRECT on csr_done; WAIT_TLB_OK -> REDIRECT on tlb_done.
//  REDIRECT: set_pc=1, pc_redirect=target for 1 cycle; next state IDLE. fetch_hold=1 in every non-IDLE
//   state incl. REDIRECT; deasserts the cycle after set_pc. New detects in REDIRECT are not sampled.
//  Watchdog: wdog_cnt counts every cycle in a WAIT_* state, cleared in IDLE; at all-ones -> REDIRECT,
//   wdog_err pulses with set_pc.
//  flush: any state -> IDLE next edge; clears counters; suppresses set_pc/flush_front/squash that
//   cycle; a bundle_fire coinciding with flush is not sampled. Flush wins over every other event.
//  Same-cycle from_ex and done: only from_ex acts; done must be re-seen in WAIT_*_OK.
// TESTING
//  Reset mid-WAIT_CSR_OK: rstn=0 -> state IDLE, fetch_hold=0, set_pc=0 immediately (async).
//  bundle_pc=0x1c000010, csr_flag=01 -> flush_front 1 cyc, squash_slot1=1; csr_from_ex then csr_done
//   -> set_pc 1 cyc with pc_redirect=0x1c000014, then IDLE.
//  ibar_flag=10 at pc 0x1c000020, ibar_from_ex, dcache_idle toggles 1,0,1,1 -> redirect only after
//   2nd consecutive idle, target 0x1c000028; squash_slot1=0.
//  csr_flag=10 & tlb_flag=01 same bundle -> slot0 TLB path chosen, target bundle_pc+4.
//  flush asserted in WAIT_TLB_OK same cycle as tlb_done -> IDLE, no set_pc ever.
//  WAIT_EX_CSR with no csr_from_ex for 1023 cycles -> REDIRECT, wdog_err=1, set_pc=1; bundle_pc
//   0xFFFFFFFC slot1 -> target 0x00000004 (wrap).

Source files
------------

// File: rtl/fetch_priv_ctrl.sv
// Front-end sequencer for privileged instructions (ibar / CSR write / TLB op): kills younger fetch,
// holds IF until the instruction's side effect completes in the backend, then redirects to PC+4.
module fetch_priv_ctrl #(
  parameter int IDLE_CYC = 2,
  parameter int WDOG_W   = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        bundle_fire,
  input  logic [31:0] bundle_pc,
  input  logic [1:0]  ibar_flag,
  input  logic [1:0]  csr_flag,
  input  logic [1:0]  tlb_flag,
  input  logic        ibar_from_ex,
  input  logic        csr_from_ex,
  input  logic        tlb_from_ex,
  input  logic        icache_idle,
  input  logic        dcache_idle,
  input  logic        csr_done,
  input  logic        tlb_done,
  output logic        fetch_hold,
  output logic        flush_front,
  output logic        squash_slot1,
  output logic        set_pc,
  output logic [31:0] pc_redirect,
  output logic        wdog_err,
  output logic        busy
);

  localparam logic [2:0] IDLE            = 3'b000;
  localparam logic [2:0] WAIT_EX_IBAR    = 3'b001;
  localparam logic [2:0] WAIT_EX_CSR     = 3'b010;
  localparam logic [2:0] WAIT_EX_TLB     = 3'b111;
  localparam logic [2:0] WAIT_CACHE_IDLE = 3'b011;
  localparam logic [2:0] WAIT_CSR_OK     = 3'b100;
  localparam logic [2:0] WAIT_TLB_OK     = 3'b101;
  localparam logic [2:0] REDIRECT        = 3'b110;

  localparam int IW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);
  // Checked before the increment, so the last wait cycle is the one that makes the count all-ones.
  localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

  logic [2:0]        state, state_nxt, detect_state;
  logic [31:0]       target, detect_target;
  logic [IW-1:0]     idle_cnt;
  logic [WDOG_W-1:0] wdog_cnt;
  logic              flush_front_q, wdog_q;
  logic              slot0_hit, slot1_hit, sel_ibar, sel_csr;
  logic              detect, in_wait, both_idle, wdog_sat;

  assign slot0_hit = ibar_flag[0] | csr_flag[0] | tlb_flag[0];
  assign slot1_hit = ibar_flag[1] | csr_flag[1] | tlb_flag[1];
  assign sel_ibar  = slot0_hit ? ibar_flag[0] : ibar_flag[1];
  assign sel_csr   = slot0_hit ? csr_flag[0]  : csr_flag[1];

  assign detect        = (state == IDLE) & bundle_fire & ~flush & (slot0_hit | slot1_hit);
  assign detect_state  = sel_ibar ? WAIT_EX_IBAR : (sel_csr ? WAIT_EX_CSR : WAIT_EX_TLB);
  assign detect_target = bundle_pc + (slot0_hit ? 32'd4 : 32'd8);

  assign in_wait   = (state != IDLE) && (state != REDIRECT);
  assign both_idle = icache_idle & dcache_idle;
  assign wdog_sat  = in_wait && (wdog_cnt == WDOG_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:            if (detect) state_nxt = detect_state;
      WAIT_EX_IBAR:    if (ibar_from_ex) state_nxt = WAIT_CACHE_IDLE;
      WAIT_EX_CSR:     if (csr_from_ex) state_nxt = WAIT_CSR_OK;
      WAIT_EX_TLB:     if (tlb_from_ex) state_nxt = WAIT_TLB_OK;
      WAIT_CACHE_IDLE: if (both_idle && (idle_cnt == IDLE_LAST)) state_nxt = REDIRECT;
      WAIT_CSR_OK:     if (csr_done) state_nxt = REDIRECT;
      WAIT_TLB_OK:     if (tlb_done) state_nxt = REDIRECT;
      REDIRECT:        state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
    if (wdog_sat) state_nxt = REDIRECT;
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      target        <= '0;
      idle_cnt      <= '0;
      wdog_cnt      <= '0;
      flush_front_q <= 1'b0;
      wdog_q        <= 1'b0;
    end else begin
      state         <= state_nxt;
      flush_front_q <= detect;
      wdog_q        <= wdog_sat & ~flush;
      if (detect) target <= detect_target;
      if (flush || (state != WAIT_CACHE_IDLE) || !both_idle) idle_cnt <= '0;
      else idle_cnt <= idle_cnt + 1'b1;
      if (flush || !in_wait) wdog_cnt <= '0;
      else wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  // A same-cycle flush silences every strobe the block would otherwise emit.
  assign busy         = (state != IDLE);
  assign fetch_hold   = busy;
  assign set_pc       = (state == REDIRECT) & ~flush;
  assign pc_redirect  = set_pc ? target : 32'h0;
  assign wdog_err     = wdog_q & set_pc;
  assign flush_front  = flush_front_q & ~flush;
  assign squash_slot1 = detect & slot0_hit;

endmodule

// File: tb/tb_fetch_priv_ctrl.sv
// Self-checking bench for fetch_priv_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model of the sequencer.
module tb_fetch_priv_ctrl;

  localparam int IDLE_CYC   = 2;
  localparam int WDOG_W     = 10;
  localparam int WAIT_LIMIT = (1 << WDOG_W) - 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush, bundle_fire;
  logic [31:0] bundle_pc;
  logic [1:0]  ibar_flag, csr_flag, tlb_flag;
  logic        ibar_from_ex, csr_from_ex, tlb_from_ex;
  logic        icache_idle, dcache_idle, csr_done, tlb_done;
  logic        fetch_hold, flush_front, squash_slot1, set_pc, wdog_err, busy;
  logic [31:0] pc_redirect;

  int n_checks = 0;
  int n_fails  = 0;
  bit check_en = 1'b0;

  fetch_priv_ctrl #(.IDLE_CYC(IDLE_CYC), .WDOG_W(WDOG_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .bundle_fire(bundle_fire), .bundle_pc(bundle_pc),
    .ibar_flag(ibar_flag), .csr_flag(csr_flag), .tlb_flag(tlb_flag),
    .ibar_from_ex(ibar_from_ex), .csr_from_ex(csr_from_ex), .tlb_from_ex(tlb_from_ex),
    .icache_idle(icache_idle), .dcache_idle(dcache_idle), .csr_done(csr_done), .tlb_done(tlb_done),
    .fetch_hold(fetch_hold), .flush_front(flush_front), .squash_slot1(squash_slot1),
    .set_pc(set_pc), .pc_redirect(pc_redirect), .wdog_err(wdog_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction view: one privileged instruction in flight, whether EX has seen it, how long we
  // have waited, the run of idle cache cycles, and whether the redirect is due this cycle.
  typedef struct packed {
    logic        active;
    logic        ex_seen;
    logic        redirect;
    logic        wdog;
    logic        ff;
    logic [1:0]  kind;
    logic [10:0] waited;
    logic [3:0]  idle_run;
    logic [31:0] target;
  } model_t;

  model_t m;

  function automatic model_t model_step(input model_t cur);
    model_t     nx;
    logic [1:0] any;
    int         s;
    nx  = cur;
    any = ibar_flag | csr_flag | tlb_flag;
    nx.ff = !cur.active && bundle_fire && !flush && (any != 2'b00);
    if (flush) begin
      nx.active = 0; nx.redirect = 0; nx.ex_seen = 0; nx.wdog = 0;
      nx.waited = '0; nx.idle_run = '0;
    end else if (!cur.active) begin
      if (nx.ff) begin
        s = any[0] ? 0 : 1;
        nx.active   = 1;
        nx.kind     = ibar_flag[s] ? 2'd0 : (csr_flag[s] ? 2'd1 : 2'd2);
        nx.target   = bundle_pc + 32'(4 * (s + 1));
        nx.ex_seen  = 0; nx.redirect = 0; nx.wdog = 0;
        nx.waited   = '0; nx.idle_run = '0;
      end
    end else if (cur.redirect) begin
      nx.active = 0; nx.redirect = 0; nx.wdog = 0;
    end else begin
      nx.waited = cur.waited + 11'd1;
      if (int'(nx.waited) == WAIT_LIMIT) begin
        nx.redirect = 1; nx.wdog = 1;
      end else if (!cur.ex_seen) begin
        nx.ex_seen = (cur.kind == 2'd0 && ibar_from_ex) || (cur.kind == 2'd1 && csr_from_ex) ||
                     (cur.kind == 2'd2 && tlb_from_ex);
      end else begin
        case (cur.kind)
          2'd0: begin
            if (icache_idle && dcache_idle) begin
              nx.idle_run = cur.idle_run + 4'd1;
              if (int'(nx.idle_run) == IDLE_CYC) nx.redirect = 1;
            end else nx.idle_run = '0;
          end
          2'd1:    nx.redirect = csr_done;
          default: nx.redirect = tlb_done;
        endcase
      end
    end
    return nx;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m <= '0;
    else m <= model_step(m);
  end

  always @(negedge clk) begin : compare
    logic [1:0] any;
    logic       det, exp_set;
    if (rstn && check_en) begin
      any     = ibar_flag | csr_flag | tlb_flag;
      det     = !m.active && bundle_fire && !flush && (any != 2'b00);
      exp_set = m.redirect && !flush;
      check_output("busy", 32'(busy), 32'(m.active));
      check_output("fetch_hold", 32'(fetch_hold), 32'(m.active));
      check_output("set_pc", 32'(set_pc), 32'(exp_set));
      check_output("pc_redirect", pc_redirect, exp_set ? m.target : 32'h0);
      check_output("wdog_err", 32'(wdog_err), 32'(exp_set && m.wdog));
      check_output("flush_front", 32'(flush_front), 32'(m.ff && !flush));
      check_output("squash_slot1", 32'(squash_slot1), 32'(det && any[0]));
    end
  end

  task automatic clear_inputs();
    flush = 0; bundle_fire = 0; bundle_pc = '0;
    ibar_flag = '0; csr_flag = '0; tlb_flag = '0;
    ibar_from_ex = 0; csr_from_ex = 0; tlb_from_ex = 0;
    icache_idle = 0; dcache_idle = 0; csr_done = 0; tlb_done = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [31:0] pc, input logic [1:0] ib, input logic [1:0] cs,
                      input logic [1:0] tl);
    bundle_fire = 1; bundle_pc = pc; ibar_flag = ib; csr_flag = cs; tlb_flag = tl;
  endtask

  task automatic apply_stimulus();
    flush        = ($urandom_range(31) == 0);
    bundle_fire  = ($urandom_range(3) == 0);
    bundle_pc    = $urandom & 32'hFFFF_FFFC;
    ibar_flag    = ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : 2'b00;
    csr_flag     = ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : 2'b00;
    tlb_flag     = ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : 2'b00;
    ibar_from_ex = ($urandom_range(2) == 0);
    csr_from_ex  = ($urandom_range(2) == 0);
    tlb_from_ex  = ($urandom_range(2) == 0);
    icache_idle  = ($urandom_range(3) != 0);
    dcache_idle  = ($urandom_range(3) != 0);
    csr_done     = ($urandom_range(2) == 0);
    tlb_done     = ($urandom_range(2) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int  k;
    bit  seen;
    clear_inputs();
    rstn = 0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset busy", 32'(busy), 32'h0);
    check_output("reset fetch_hold", 32'(fetch_hold), 32'h0);
    check_output("reset set_pc", 32'(set_pc), 32'h0);
    check_output("reset pc_redirect", pc_redirect, 32'h0);
    check_output("reset flush_front", 32'(flush_front), 32'h0);
    check_output("reset wdog_err", 32'(wdog_err), 32'h0);
    rstn = 1;
    check_en = 1;
    next_cycle();

    $display("[TB] CSR write in slot0");
    fire(32'h1c00_0010, 2'b00, 2'b01, 2'b00);
    @(negedge clk); check_output("csr squash_slot1", 32'(squash_slot1), 32'h1);
    next_cycle(); clear_inputs();
    @(negedge clk); check_output("csr flush_front on", 32'(flush_front), 32'h1);
    next_cycle();
    @(negedge clk); check_output("csr flush_front off", 32'(flush_front), 32'h0);
    next_cycle(); csr_from_ex = 1;
    next_cycle(); csr_from_ex = 0; csr_done = 1;
    @(negedge clk); check_output("csr set_pc early", 32'(set_pc), 32'h0);
    next_cycle(); clear_inputs();
    @(negedge clk);
    check_output("csr set_pc", 32'(set_pc), 32'h1);
    check_output("csr pc_redirect", pc_redirect, 32'h1c00_0014);
    next_cycle();
    @(negedge clk);
    check_output("csr back idle", 32'(busy), 32'h0);
    check_output("csr hold released", 32'(fetch_hold), 32'h0);

    $display("[TB] ibar in slot1 with cache idle gaps");
    next_cycle(); fire(32'h1c00_0020, 2'b10, 2'b00, 2'b00);
    @(negedge clk); check_output("ibar squash_slot1", 32'(squash_slot1), 32'h0);
    next_cycle(); clear_inputs();
    next_cycle(); ibar_from_ex = 1; icache_idle = 1;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); ibar_from_ex = 0; icache_idle = 1; dcache_idle = (i != 1);
      @(negedge clk); check_output("ibar no early set_pc", 32'(set_pc), 32'h0);
    end
    next_cycle(); clear_inputs();
    @(negedge clk);
    check_output("ibar set_pc", 32'(set_pc), 32'h1);
    check_output("ibar pc_redirect", pc_redirect, 32'h1c00_0028);

    $display("[TB] slot0 TLB beats slot1 CSR");
    next_cycle(); fire(32'h1c00_0040, 2'b00, 2'b10, 2'b01);
    @(negedge clk); check_output("tlb squash_slot1", 32'(squash_slot1), 32'h1);
    next_cycle(); clear_inputs();
    next_cycle(); csr_from_ex = 1;
    next_cycle(); csr_from_ex = 0; tlb_from_ex = 1;
    next_cycle(); tlb_from_ex = 0; tlb_done = 1;
    @(negedge clk); check_output("tlb set_pc early", 32'(set_pc), 32'h0);
    next_cycle(); clear_inputs();
    @(negedge clk);
    check_output("tlb set_pc", 32'(set_pc), 32'h1);
    check_output("tlb pc_redirect", pc_redirect, 32'h1c00_0044);

    $display("[TB] flush races tlb_done");
    next_cycle(); fire(32'h1c00_0080, 2'b00, 2'b00, 2'b01);
    next_cycle(); clear_inputs();
    next_cycle(); tlb_from_ex = 1;
    next_cycle(); tlb_from_ex = 0; tlb_done = 1; flush = 1;
    @(negedge clk); check_output("flush race set_pc", 32'(set_pc), 32'h0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      next_cycle(); clear_inputs();
      @(negedge clk); if (set_pc) seen = 1;
    end
    check_output("flush never redirects", 32'(seen), 32'h0);
    check_output("flush back idle", 32'(busy), 32'h0);

    $display("[TB] async reset while waiting for csr_done");
    next_cycle(); fire(32'h1c00_00c0, 2'b00, 2'b01, 2'b00);
    next_cycle(); clear_inputs();
    next_cycle(); csr_from_ex = 1;
    next_cycle(); clear_inputs();
    check_output("pre-reset hold", 32'(fetch_hold), 32'h1);
    #2 rstn = 0;
    #1;
    check_output("async reset hold", 32'(fetch_hold), 32'h0);
    check_output("async reset busy", 32'(busy), 32'h0);
    check_output("async reset set_pc", 32'(set_pc), 32'h0);
    next_cycle(); rstn = 1;
    next_cycle();

    $display("[TB] watchdog with wrapping target");
    fire(32'hFFFF_FFFC, 2'b00, 2'b10, 2'b00);
    @(negedge clk); check_output("wdog squash_slot1", 32'(squash_slot1), 32'h0);
    k = 0;
    seen = 0;
    for (int i = 1; i <= 1100 && !seen; i++) begin
      next_cycle(); clear_inputs();
      @(negedge clk);
      if (set_pc) begin seen = 1; k = i; end
    end
    check_output("wdog redirect seen", 32'(seen), 32'h1);
    check_output("wdog latency", 32'(k), 32'd1024);
    check_output("wdog_err", 32'(wdog_err), 32'h1);
    check_output("wdog pc_redirect", pc_redirect, 32'h0000_0004);
    next_cycle();

    $display("[TB] randomized run");
    for (int i = 0; i < 4000; i++) begin
      apply_stimulus();
      next_cycle();
    end
    clear_inputs();
    repeat (2) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
